// File: rtl/poly_horner_sequencer_if.sv
// poly_horner_sequencer_if: request/result, coefficient-write and shared
// multiply/add unit signals of the Horner sequencer, grouped as one bundle.
// slave  : the sequencer side.
// master : the client / arithmetic-unit side.
interface poly_horner_sequencer_if #(
  parameter int BITS = 16,
  parameter int AW   = 2
);
  // Evaluation request and result
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] x_in;
  logic            out_valid;
  logic [BITS-1:0] x;
  logic            err;

  // Coefficient programming
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [BITS-1:0] coef_wdata;
  logic            coef_err;

  // Shared multiplier
  logic            mul_in_valid;
  logic [BITS-1:0] mul_a;
  logic [BITS-1:0] mul_b;
  logic            mul_out_valid;
  logic [BITS-1:0] mul_c;

  // Shared adder
  logic            add_in_valid;
  logic [BITS-1:0] add_a;
  logic [BITS-1:0] add_b;
  logic            add_out_valid;
  logic [BITS-1:0] add_c;

  modport slave (
    input  in_valid, x_in,
    output in_ready, out_valid, x, err,
    input  coef_we, coef_addr, coef_wdata,
    output coef_err,
    output mul_in_valid, mul_a, mul_b,
    input  mul_out_valid, mul_c,
    output add_in_valid, add_a, add_b,
    input  add_out_valid, add_c
  );

  modport master (
    output in_valid, x_in,
    input  in_ready, out_valid, x, err,
    output coef_we, coef_addr, coef_wdata,
    input  coef_err,
    input  mul_in_valid, mul_a, mul_b,
    output mul_out_valid, mul_c,
    input  add_in_valid, add_a, add_b,
    output add_out_valid, add_c
  );
endinterface

// File: rtl/poly_horner_sequencer.sv
// poly_horner_sequencer: evaluates p(x) = c0 + c1*x + ... + cDEGREE*x^DEGREE
// by Horner's rule, time-sharing one external multiply unit and one external
// add unit. Holds a programmable coefficient file and the handshake FSM.
// Optional watchdog: define POLY_SEQ_TIMEOUT_EN to abort a WAIT state after
// TIMEOUT cycles with err=1 and x=0.
module poly_horner_sequencer #(
  parameter int BITS    = 16,
  parameter int DEGREE  = 3,
  parameter int TIMEOUT = 64,
  parameter int AW      = $clog2(DEGREE + 1)
) (
  input logic                  clk,
  input logic                  rst,
  poly_horner_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_ISSUE,
    MUL_WAIT,
    ADD_ISSUE,
    ADD_WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [BITS-1:0] coef [DEGREE+1];
  logic [BITS-1:0] x_reg;
  logic [AW-1:0]   k;
  logic            addr_ok;

`ifdef POLY_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // Coefficient index range check (only matters when DEGREE+1 is not a power of two)
  always_comb begin
    addr_ok = (int'(bus.coef_addr) <= DEGREE);
  end

  // Coefficient file: writes land only while idle and in range, otherwise coef_err pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef         <= '{default: '0};
      bus.coef_err <= 1'b0;
    end else begin
      bus.coef_err <= 1'b0;
      if (bus.coef_we) begin
        if (addr_ok && (state == IDLE)) begin
          coef[bus.coef_addr] <= bus.coef_wdata;
        end else begin
          bus.coef_err <= 1'b1;
        end
      end
    end
  end

  // Horner FSM with registered handshake and operand outputs.
  // The running accumulator is not kept separately: every unit result is
  // forwarded straight into the operand register of the next issue, so the
  // operand registers already hold acc whenever *_in_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      x_reg            <= '0;
      k                <= '0;
      bus.in_ready     <= 1'b1;
      bus.out_valid    <= 1'b0;
      bus.x            <= '0;
      bus.err          <= 1'b0;
      bus.mul_in_valid <= 1'b0;
      bus.mul_a        <= '0;
      bus.mul_b        <= '0;
      bus.add_in_valid <= 1'b0;
      bus.add_a        <= '0;
      bus.add_b        <= '0;
`ifdef POLY_SEQ_TIMEOUT_EN
      wd_cnt           <= '0;
`endif
    end else begin
      bus.mul_in_valid <= 1'b0;
      bus.mul_a        <= '0;
      bus.mul_b        <= '0;
      bus.add_in_valid <= 1'b0;
      bus.add_a        <= '0;
      bus.add_b        <= '0;
      bus.out_valid    <= 1'b0;
      bus.err          <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // A coefficient write in this same cycle is not yet visible,
            // so the first multiply uses the old c[DEGREE].
            x_reg            <= bus.x_in;
            k                <= AW'(DEGREE - 1);
            bus.in_ready     <= 1'b0;
            bus.mul_in_valid <= 1'b1;
            bus.mul_a        <= coef[DEGREE];
            bus.mul_b        <= bus.x_in;
            state            <= MUL_ISSUE;
          end
        end

        MUL_ISSUE: begin
          state <= MUL_WAIT;
`ifdef POLY_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end

        MUL_WAIT: begin
          if (bus.mul_out_valid) begin
            bus.add_in_valid <= 1'b1;
            bus.add_a        <= bus.mul_c;
            bus.add_b        <= coef[k];
            state            <= ADD_ISSUE;
          end
`ifdef POLY_SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            bus.out_valid <= 1'b1;
            bus.x         <= '0;
            bus.err       <= 1'b1;
            state         <= DONE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        ADD_ISSUE: begin
          state <= ADD_WAIT;
`ifdef POLY_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end

        ADD_WAIT: begin
          if (bus.add_out_valid) begin
            if (k == '0) begin
              bus.out_valid <= 1'b1;
              bus.x         <= bus.add_c;
              bus.err       <= 1'b0;
              state         <= DONE;
            end else begin
              k                <= k - AW'(1);
              bus.mul_in_valid <= 1'b1;
              bus.mul_a        <= bus.add_c;
              bus.mul_b        <= x_reg;
              state            <= MUL_ISSUE;
            end
          end
`ifdef POLY_SEQ_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            bus.out_valid <= 1'b1;
            bus.x         <= '0;
            bus.err       <= 1'b1;
            state         <= DONE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        DONE: begin
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end

        default: begin
          bus.in_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_sequencer.sv
// tb_poly_horner_sequencer: self-checking bench for poly_horner_sequencer.
// Stub multiply/add units compute modulo 2^16 with programmable latency; the
// reference model sums c[i]*x^i directly. Watchdog case runs only when
// POLY_SEQ_TIMEOUT_EN is defined.
module tb_poly_horner_sequencer;
  localparam int BITS = 16;
  localparam int DEG  = 3;
  localparam int TO   = 64;
  localparam int MAXC = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_horner_sequencer_if #(.BITS(BITS), .AW(2)) bif ();
  poly_horner_sequencer #(.BITS(BITS), .DEGREE(DEG), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave)
  );

  // Second instance whose address space has out-of-range codes
  poly_horner_sequencer_if #(.BITS(BITS), .AW(3)) bif4 ();
  poly_horner_sequencer #(.BITS(BITS), .DEGREE(4), .TIMEOUT(TO)) dut4 (
    .clk(clk), .rst(rst), .bus(bif4.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int opnd_viol = 0;

  int lm = 2;
  int la = 3;
  bit mul_stall = 1'b0;
  bit spur_m    = 1'b0;

  logic [15:0] cref [4];
  int mul_q[$];
  int add_q[$];

  typedef struct {
    logic [15:0] xv;
    logic [15:0] exp_x;
    int          exp_lat;
  } vec_t;
  vec_t vecs [5];

  // Stub multiplier: product modulo 2^16 after lm cycles
  int          m_cnt;
  logic [15:0] m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bif.mul_out_valid <= 1'b0;
      bif.mul_c         <= '0;
      m_cnt = 0;
    end else begin
      bif.mul_out_valid <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          bif.mul_out_valid <= 1'b1;
          bif.mul_c         <= m_res;
        end
      end
      if (bif.mul_in_valid && !mul_stall) begin
        m_res = bif.mul_a * bif.mul_b;
        if (lm <= 1) begin
          bif.mul_out_valid <= 1'b1;
          bif.mul_c         <= m_res;
        end else begin
          m_cnt = lm - 1;
        end
      end
      if (spur_m) begin
        bif.mul_out_valid <= 1'b1;
        bif.mul_c         <= 16'hDEAD;
      end
    end
  end

  // Stub adder: sum modulo 2^16 after la cycles
  int          a_cnt;
  logic [15:0] a_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bif.add_out_valid <= 1'b0;
      bif.add_c         <= '0;
      a_cnt = 0;
    end else begin
      bif.add_out_valid <= 1'b0;
      if (a_cnt > 0) begin
        a_cnt = a_cnt - 1;
        if (a_cnt == 0) begin
          bif.add_out_valid <= 1'b1;
          bif.add_c         <= a_res;
        end
      end
      if (bif.add_in_valid) begin
        a_res = bif.add_a + bif.add_b;
        if (la <= 1) begin
          bif.add_out_valid <= 1'b1;
          bif.add_c         <= a_res;
        end else begin
          a_cnt = la - 1;
        end
      end
    end
  end

  // Operands must read zero whenever their valid is low
  always @(negedge clk) begin
    if (!rst) begin
      if (!bif.mul_in_valid && (bif.mul_a != 16'h0 || bif.mul_b != 16'h0)) opnd_viol++;
      if (!bif.add_in_valid && (bif.add_a != 16'h0 || bif.add_b != 16'h0)) opnd_viol++;
    end
  end

  function automatic logic [15:0] poly_ref(input logic [15:0] xv);
    logic [15:0] s;
    logic [15:0] pw;
    s  = 16'h0;
    pw = 16'h1;
    for (int i = 0; i < 4; i++) begin
      s  = s + cref[i] * pw;
      pw = pw * xv;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_coef(input logic [1:0] addr, input logic [15:0] data);
    @(negedge clk);
    bif.coef_we    = 1'b1;
    bif.coef_addr  = addr;
    bif.coef_wdata = data;
    @(negedge clk);
    bif.coef_we = 1'b0;
    chk("coef_err_idle_write", {31'b0, bif.coef_err}, 32'd0);
    cref[addr] = data;
  endtask

  // One evaluation; optional coefficient write presented in cycle wr_cyc
  task automatic run_eval(input logic [15:0] xv, input int wr_cyc,
                          input logic [1:0] wa, input logic [15:0] wd,
                          input logic exp_cerr,
                          output logic [15:0] res, output logic er, output int lat);
    bit got;
    @(negedge clk);
    chk("in_ready_before_request", {31'b0, bif.in_ready}, 32'd1);
    bif.in_valid = 1'b1;
    bif.x_in     = xv;
    if (wr_cyc == 0) begin
      bif.coef_we    = 1'b1;
      bif.coef_addr  = wa;
      bif.coef_wdata = wd;
    end
    mul_q.delete();
    add_q.delete();
    got = 1'b0;
    res = '0;
    er  = 1'b0;
    lat = -1;
    for (int n = 1; n <= MAXC && !got; n++) begin
      @(negedge clk);
      bif.in_valid = 1'b0;
      if (wr_cyc >= 0 && n == wr_cyc + 1) begin
        bif.coef_we = 1'b0;
        chk("coef_err_pulse", {31'b0, bif.coef_err}, {31'b0, exp_cerr});
      end
      if (n == wr_cyc) begin
        bif.coef_we    = 1'b1;
        bif.coef_addr  = wa;
        bif.coef_wdata = wd;
      end
      if (bif.mul_in_valid) mul_q.push_back(n);
      if (bif.add_in_valid) add_q.push_back(n);
      if (bif.out_valid) begin
        got = 1'b1;
        lat = n;
        res = bif.x;
        er  = bif.err;
      end
    end
    bif.coef_we = 1'b0;
    if (!got) chk("out_valid_within_budget", 32'd0, 32'd1);
    @(negedge clk);
    chk("out_valid_single_cycle", {31'b0, bif.out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got expired, want finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] res;
    logic [15:0] expv;
    logic        er;
    int          lat;
    int          ov_seen;
    int          a4 [3];
    bit          e4 [3];
    int          exp_mul [3];
    int          exp_add [3];

    bif.in_valid = 1'b0;   bif.x_in = '0;
    bif.coef_we  = 1'b0;   bif.coef_addr = '0; bif.coef_wdata = '0;
    bif4.in_valid = 1'b0;  bif4.x_in = '0;
    bif4.coef_we  = 1'b0;  bif4.coef_addr = '0; bif4.coef_wdata = '0;
    bif4.mul_out_valid = 1'b0; bif4.mul_c = '0;
    bif4.add_out_valid = 1'b0; bif4.add_c = '0;
    for (int i = 0; i < 4; i++) cref[i] = 16'h0;

    // Expected values for c = {3C00, 39A0, 33C4, 0000}, integer stub units
    vecs[0] = '{xv: 16'h0000, exp_x: 16'h3C00, exp_lat: 22};
    vecs[1] = '{xv: 16'h0001, exp_x: 16'hA964, exp_lat: 22};
    vecs[2] = '{xv: 16'h0002, exp_x: 16'h7E50, exp_lat: 22};
    vecs[3] = '{xv: 16'h3800, exp_x: 16'h3C00, exp_lat: 22};
    vecs[4] = '{xv: 16'hFFFF, exp_x: 16'h3624, exp_lat: 22};
    exp_mul = '{1, 8, 15};
    exp_add = '{4, 11, 18};
    a4 = '{4, 5, 7};
    e4 = '{1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_in_ready",     {31'b0, bif.in_ready},     32'd1);
    chk("reset_out_valid",    {31'b0, bif.out_valid},    32'd0);
    chk("reset_x",            {16'b0, bif.x},            32'd0);
    chk("reset_err",          {31'b0, bif.err},          32'd0);
    chk("reset_coef_err",     {31'b0, bif.coef_err},     32'd0);
    chk("reset_mul_in_valid", {31'b0, bif.mul_in_valid}, 32'd0);
    chk("reset_add_in_valid", {31'b0, bif.add_in_valid}, 32'd0);
    rst = 1'b0;

    // Coefficients clear to zero on reset
    run_eval(16'h1234, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("zero_coef_result", {16'b0, res}, 32'd0);

    write_coef(2'd0, 16'h3C00);
    write_coef(2'd1, 16'h39A0);
    write_coef(2'd2, 16'h33C4);
    write_coef(2'd3, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      run_eval(vecs[i].xv, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
      chk($sformatf("vec%0d_x", i),   {16'b0, res}, {16'b0, vecs[i].exp_x});
      chk($sformatf("vec%0d_err", i), {31'b0, er},  32'd0);
      chk($sformatf("vec%0d_lat", i), lat,          vecs[i].exp_lat);
    end

    // Issue cycles relative to accept (Lm=2, La=3)
    run_eval(16'h0002, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("mul_issue_count", mul_q.size(), 32'd3);
    chk("add_issue_count", add_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mul_issue_cycle%0d", i), (i < mul_q.size()) ? mul_q[i] : -1, exp_mul[i]);
      chk($sformatf("add_issue_cycle%0d", i), (i < add_q.size()) ? add_q[i] : -1, exp_add[i]);
    end

    // Stray multiplier result while idle is ignored
    @(negedge clk);
    spur_m = 1'b1;
    @(negedge clk);
    spur_m = 1'b0;
    @(negedge clk);
    chk("stray_mul_in_ready",  {31'b0, bif.in_ready},  32'd1);
    chk("stray_mul_out_valid", {31'b0, bif.out_valid}, 32'd0);
    run_eval(16'h0001, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("after_stray_x", {16'b0, res}, 32'h0000A964);

    // Write during MUL_WAIT is rejected and does not alter the result
    run_eval(16'h0002, 2, 2'd1, 16'h1234, 1'b1, res, er, lat);
    chk("busy_write_result", {16'b0, res}, 32'h00007E50);
    run_eval(16'h0002, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("busy_write_dropped", {16'b0, res}, 32'h00007E50);

    // Same write while idle takes effect
    write_coef(2'd1, 16'h1234);
    expv = poly_ref(16'h0002);
    run_eval(16'h0002, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("idle_write_new_c1", {16'b0, res}, {16'b0, expv});

    // Write to c[DEGREE] in the accept cycle: this run uses the old value
    expv = poly_ref(16'h0003);
    run_eval(16'h0003, 0, 2'd3, 16'h0101, 1'b0, res, er, lat);
    chk("accept_cycle_write_old_c3", {16'b0, res}, {16'b0, expv});
    cref[3] = 16'h0101;
    expv = poly_ref(16'h0003);
    run_eval(16'h0003, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("accept_cycle_write_new_c3", {16'b0, res}, {16'b0, expv});

    // Randomized coefficients, inputs and unit latencies
    for (int it = 0; it < 20; it++) begin
      lm = int'($urandom_range(1, 4));
      la = int'($urandom_range(1, 4));
      write_coef(2'($urandom_range(0, 3)), 16'($urandom));
      bif.x_in = 16'($urandom);
      expv = poly_ref(bif.x_in);
      run_eval(bif.x_in, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
      chk($sformatf("rand%0d_x", it),   {16'b0, res}, {16'b0, expv});
      chk($sformatf("rand%0d_lat", it), lat,          1 + DEG * (2 + lm + la));
    end
    lm = 2;
    la = 3;

    // Reset during ADD_WAIT (cycle 5 after accept)
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.x_in     = 16'h0002;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      bif.in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midreset_in_ready",     {31'b0, bif.in_ready},     32'd1);
    chk("midreset_mul_in_valid", {31'b0, bif.mul_in_valid}, 32'd0);
    chk("midreset_add_in_valid", {31'b0, bif.add_in_valid}, 32'd0);
    chk("midreset_out_valid",    {31'b0, bif.out_valid},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cref[i] = 16'h0;
    ov_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bif.out_valid) ov_seen++;
    end
    chk("midreset_no_result", ov_seen, 32'd0);
    write_coef(2'd0, 16'h3C00);
    write_coef(2'd1, 16'h39A0);
    write_coef(2'd2, 16'h33C4);
    write_coef(2'd3, 16'h0000);
    run_eval(16'h0002, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("after_reset_x",   {16'b0, res}, 32'h00007E50);
    chk("after_reset_lat", lat,          32'd22);

    // Address range check on the DEGREE=4 instance
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bif4.coef_we    = 1'b1;
      bif4.coef_addr  = 3'(a4[i]);
      bif4.coef_wdata = 16'h5555;
      @(negedge clk);
      bif4.coef_we = 1'b0;
      chk($sformatf("deg4_addr%0d_coef_err", a4[i]), {31'b0, bif4.coef_err}, {31'b0, e4[i]});
    end

`ifdef POLY_SEQ_TIMEOUT_EN
    // Multiplier never answers: watchdog aborts at 1 + 1 + TIMEOUT
    mul_stall = 1'b1;
    run_eval(16'h0002, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("timeout_lat", lat,          2 + TO);
    chk("timeout_err", {31'b0, er},  32'd1);
    chk("timeout_x",   {16'b0, res}, 32'd0);
    mul_stall = 1'b0;
    run_eval(16'h0002, -1, 2'd0, 16'h0, 1'b0, res, er, lat);
    chk("after_timeout_x", {16'b0, res}, 32'h00007E50);
`endif

    chk("operands_zero_when_invalid", opnd_viol, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/poly_horner_sequencer.md
# poly_horner_sequencer

Controller that evaluates p(x) = c0 + c1·x + … + cDEGREE·x^DEGREE by Horner's rule. It time-shares one external `multiply` unit and one external `add` unit of the precision library. The sequencer owns a small programmable coefficient register file and a handshake FSM. Pairing it with a single multiplier/adder pair replaces the fully unrolled polynomial-exp datapath when area matters more than throughput.

## Interface
Parameters:
- `BITS`, 16: operand width; coefficient, x and result width.
- `DEGREE`, 3: polynomial degree, legal range 1..7.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only with `POLY_SEQ_TIMEOUT_EN`.
- `AW`, $clog2(DEGREE+1): coefficient address width. Derived; do not override.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  request.
- `in_ready`  out  1  high only in IDLE.
- `x_in`  in  BITS  evaluation point.
- `out_valid`  out  1  one-cycle result strobe.
- `x`  out  BITS  result; held until the next result.
- `err`  out  1  qualified by `out_valid`; timeout occurred.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  AW  coefficient index k.
- `coef_wdata`  in  BITS  value of ck.
- `coef_err`  out  1  one-cycle pulse: write was rejected.
- `mul_in_valid`, `mul_a`, `mul_b`  out  1/BITS/BITS  multiplier request.
- `mul_out_valid`, `mul_c`  in  1/BITS  multiplier result.
- `add_in_valid`, `add_a`, `add_b`  out  1/BITS/BITS  adder request.
- `add_out_valid`, `add_c`  in  1/BITS  adder result.

## Operation
- Reset: FSM goes to IDLE. All outputs are 0 except `in_ready`, which is 1. All coefficients, `acc`, `x_reg` and `k` are 0.
- IDLE: on `in_valid`, capture `x_reg`=x_in, `acc`=c[DEGREE], `k`=DEGREE-1, then go to MUL_ISSUE.
- MUL_ISSUE, one cycle:
  - Drive `mul_in_valid`=1, `mul_a`=acc, `mul_b`=x_reg.
  - Go to MUL_WAIT.
- MUL_WAIT: on `mul_out_valid`, set acc=mul_c and go to ADD_ISSUE.
- ADD_ISSUE, one cycle:
  - Drive `add_in_valid`=1, `add_a`=acc, `add_b`=c[k].
  - Go to ADD_WAIT.
- ADD_WAIT: on `add_out_valid`, set acc=add_c.
  - If k==0, go to DONE.
  - Otherwise set k=k-1 and go to MUL_ISSUE.
- DONE, one cycle:
  - `out_valid`=1 and `x`=acc.
  - `err` is 0 on a normal completion.
  - Go to IDLE.
- The `*_a`/`*_b` outputs are 0 whenever the corresponding `*_in_valid` is 0.
- A `mul_out_valid` or `add_out_valid` arriving in any state other than its own WAIT state is ignored.
- Coefficient writes:
  - In IDLE, a write takes effect next cycle, including the cycle in which `in_valid` is accepted. In that cycle, `acc` takes the old c[DEGREE].
  - In any other state, the write is dropped and `coef_err` pulses for one cycle.
  - An address greater than DEGREE is dropped with a `coef_err` pulse, in any state.
- The sequencer never does arithmetic itself. All arithmetic, and the rounding it implies, happens in the external units.
- Reset mid-operation returns to IDLE immediately. No result is produced.

## Timing
- The request is accepted at cycle 0. Let Lm and La be the unit latencies, measured from `*_in_valid` to `*_out_valid`.
- Each Horner step takes 2+Lm+La cycles.
- `out_valid` rises at cycle 1 + DEGREE·(2+Lm+La).
- `in_ready` is 1 again in the cycle after DONE. Back-to-back requests are therefore separated by at least 2 + DEGREE·(2+Lm+La) cycles.
- At most one operation is outstanding per unit at any time. No backpressure is applied toward the units.

## Configuration
- `POLY_SEQ_TIMEOUT_EN` defined:
  - A counter clears on entry to MUL_WAIT or ADD_WAIT and increments each cycle in those states.
  - When the count reaches TIMEOUT, the FSM goes to DONE with `err`=1 and `x`=0.
- `POLY_SEQ_TIMEOUT_EN` not defined:
  - The WAIT states wait indefinitely.
  - `err` is tied to 0 and no counter is synthesized.

## Test plan
Unless stated otherwise, the bench uses the library `multiply`/`add` in HALF precision, DEGREE=3, and c0..c3 = 0x3C00, 0x39A0, 0x33C4, 0x0000.
- x_in=0x0000 → single `out_valid` with x=0x3C00 and err=0.
- x_in=0x3800 (0.5) → x within 2 ULP of 0x3DA6 (≈1.412). Compare against a real-valued model.
- Latency with stub units (Lm=2, La=3): accept at cycle 0 → `out_valid` at cycle 22. `mul_in_valid` pulses exactly at cycles 1, 8, 15; `add_in_valid` at cycles 4, 11, 18.
- `coef_we` to addr 1 during MUL_WAIT → `coef_err` pulse, result unchanged. The same write in IDLE followed by a new request uses the new c1.
- `rst` asserted during ADD_WAIT → next cycle `in_ready`=1 and `mul_in_valid`=`add_in_valid`=`out_valid`=0. A new request then completes normally.
- With `POLY_SEQ_TIMEOUT_EN` and a stub multiplier that never responds: `out_valid` with err=1 and x=0 at cycle 1+1+TIMEOUT after accept, i.e. cycle 66 for TIMEOUT=64.
